vmon_m2h_packetizer: RTL and testbench



---
 rtl/vmon_m2h_packetizer.sv | 176 +++++++++++++++++
 tb/tb_vmon_m2h_packetizer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmon_m2h_packetizer.sv
// Bus-monitor event packetizer: buffers transaction events in a small FIFO and
// serializes each one as a framed, checksummed byte stream on a valid/ready port.
module vmon_m2h_packetizer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ev_valid,
    input  logic                          ev_write,
    input  logic [ADDR_WIDTH-1:0]         ev_addr,
    input  logic [DATA_WIDTH-1:0]         ev_data,
    output logic                          m2h_valid,
    input  logic                          m2h_ready,
    output logic [7:0]                    m2h_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count,
    output logic                          busy
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_TYPE,
        S_ADDR,
        S_DATA,
        S_CSUM
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } event_t;

    state_t                state_q, state_d;
    event_t                mem [FIFO_DEPTH];
    event_t                rd_event;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  full, empty, push, pop, drop, hs;
    logic                  pkt_write;
    logic [ADDR_WIDTH-1:0] pkt_addr;
    logic [DATA_WIDTH-1:0] pkt_data;
    logic [7:0]            csum;
    logic [2:0]            byte_cnt;
    logic                  addr_last, data_last;

    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = ev_valid & (~full | pop);
    assign drop      = ev_valid & full & ~pop;
    assign m2h_valid = (state_q != S_IDLE);
    assign hs        = m2h_valid & m2h_ready;
    assign busy      = m2h_valid | ~empty;
    assign rd_event  = mem[rd_ptr];
    assign addr_last = (byte_cnt == 3'(ADDR_BYTES - 1));
    assign data_last = (byte_cnt == 3'(DATA_BYTES - 1));

    // NOTE: the event storage has no reset; validity is tracked by the pointers
    // and level alone, which keeps the array free of a reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{write: ev_write, addr: ev_addr, data: ev_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        m2h_data = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                m2h_data = 8'hA5;
                if (hs) state_d = S_TYPE;
            end
            S_TYPE: begin
                m2h_data = pkt_write ? 8'h02 : 8'h01;
                if (hs) state_d = S_ADDR;
            end
            S_ADDR: begin
                m2h_data = pkt_addr[7:0];
                if (hs && addr_last) state_d = S_DATA;
            end
            S_DATA: begin
                m2h_data = pkt_data[7:0];
                if (hs && data_last) state_d = S_CSUM;
            end
            S_CSUM: begin
                m2h_data = csum;
                // Chain straight into the next packet so there is no idle gap.
                if (hs) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_SYNC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and data are shifted out LSB first, so the outgoing byte is always bits [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_write <= 1'b0;
            pkt_addr  <= '0;
            pkt_data  <= '0;
            csum      <= '0;
            byte_cnt  <= '0;
        end else if (pop) begin
            pkt_write <= rd_event.write;
            pkt_addr  <= rd_event.addr;
            pkt_data  <= rd_event.data;
            csum      <= '0;
            byte_cnt  <= '0;
        end else if (hs) begin
            case (state_q)
                S_TYPE: csum <= csum + m2h_data;
                S_ADDR: begin
                    csum     <= csum + m2h_data;
                    pkt_addr <= pkt_addr >> 8;
                    byte_cnt <= addr_last ? 3'd0 : byte_cnt + 3'd1;
                end
                S_DATA: begin
                    csum     <= csum + m2h_data;
                    pkt_data <= pkt_data >> 8;
                    byte_cnt <= data_last ? 3'd0 : byte_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vmon_m2h_packetizer.sv
// Self-checking bench for vmon_m2h_packetizer: queue-based event/packet model
// compared every cycle, plus directed literal checks from hand-worked packets.
module tb_vmon_m2h_packetizer;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int AB      = AW / 8;
    localparam int DB      = DW / 8;
    localparam int PKT_LEN = 2 + AB + DB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ev_valid = 1'b0;
    logic          ev_write = 1'b0;
    logic [AW-1:0] ev_addr = '0;
    logic [DW-1:0] ev_data = '0;
    logic          m2h_ready = 1'b0;
    logic          m2h_valid;
    logic [7:0]    m2h_data;
    logic [2:0]    fifo_level;
    logic [15:0]   drop_count;
    logic          busy;

    vmon_m2h_packetizer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_write(ev_write),
        .ev_addr(ev_addr), .ev_data(ev_data), .m2h_valid(m2h_valid),
        .m2h_ready(m2h_ready), .m2h_data(m2h_data), .fifo_level(fifo_level),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ev_s;

    // Model: pending events, bytes of the packet being sent, and bytes still to go.
    ev_s        mq[$];
    logic [7:0] cur [PKT_LEN];
    int         rem   = 0;
    int         drops = 0;
    logic [7:0] cap[$];
    logic [7:0] ref_cap[$];
    bit         checking = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    bit  m_hs, m_pop, m_accept;
    ev_s m_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void load_packet(input ev_s e);
        logic [7:0] sum;
        cur[0] = 8'hA5;
        cur[1] = e.w ? 8'h02 : 8'h01;
        sum    = cur[1];
        for (int i = 0; i < AB; i++) begin
            cur[2 + i] = e.a[8*i +: 8];
            sum        = sum + cur[2 + i];
        end
        for (int i = 0; i < DB; i++) begin
            cur[2 + AB + i] = e.d[8*i +: 8];
            sum             = sum + cur[2 + AB + i];
        end
        cur[PKT_LEN-1] = sum;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            rem   = 0;
            drops = 0;
        end else begin
            m_hs     = (rem > 0) && m2h_ready;
            m_pop    = (mq.size() > 0) && (rem == 0 || (rem == 1 && m_hs));
            m_accept = ev_valid && (mq.size() < DEPTH || m_pop);
            if (m_hs) rem--;
            if (m_pop) begin
                m_ev = mq.pop_front();
                load_packet(m_ev);
                rem = PKT_LEN;
            end
            if (ev_valid) begin
                if (m_accept) mq.push_back('{ev_write, ev_addr, ev_data});
                else if (drops < 65535) drops++;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("valid", 32'(m2h_valid), 32'(rem > 0));
            if (rem > 0) check("data", 32'(m2h_data), 32'(cur[PKT_LEN-rem]));
            check("level", 32'(fifo_level), 32'(mq.size()));
            check("drops", 32'(drop_count), 32'(drops));
            check("busy", 32'(busy), 32'(rem > 0 || mq.size() > 0));
            if (m2h_valid && m2h_ready) cap.push_back(m2h_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_valid = 1'b1;
        ev_write = w;
        ev_addr  = a;
        ev_data  = d;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic drain(input bit random_ready);
        int k = 0;
        ev_valid = 1'b0;
        while ((rem > 0 || mq.size() > 0) && k < 3000) begin
            m2h_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        m2h_ready = 1'b1;
        check("drain_timeout", 32'(k >= 3000), 32'd0);
    endtask

    logic [7:0]    exp_w [PKT_LEN];
    logic [7:0]    exp_r [PKT_LEN];
    logic [AW-1:0] ov_addr [7];
    ev_s           bp [3];

    initial begin
        exp_w = '{8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E};
        exp_r = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

        tick();
        checking = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(m2h_valid), 32'd0);
        check("rst_data", 32'(m2h_data), 32'h00);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single write: sync byte two cycles after the event.
        m2h_ready = 1'b1;
        tick();
        cap.delete();
        send(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        check("wr_n1_valid", 32'(m2h_valid), 32'd0);
        check("wr_n1_level", 32'(fifo_level), 32'd1);
        tick();
        check("wr_n2_valid", 32'(m2h_valid), 32'd1);
        check("wr_n2_sync", 32'(m2h_data), 32'hA5);
        drain(1'b0);
        check("wr_busy_end", 32'(busy), 32'd0);
        check("wr_len", 32'(cap.size()), 32'(PKT_LEN));
        for (int i = 0; i < PKT_LEN && i < cap.size(); i++) check("wr_byte", 32'(cap[i]), 32'(exp_w[i]));

        // Single read with checksum wrap to 0x00.
        cap.delete();
        send(1'b0, 32'h0000_0000, 32'h0000_00FF);
        drain(1'b0);
        check("rd_len", 32'(cap.size()), 32'(PKT_LEN));
        for (int i = 0; i < PKT_LEN && i < cap.size(); i++) check("rd_byte", 32'(cap[i]), 32'(exp_r[i]));

        // Back-pressure: same three events with ready high, then ready random.
        for (int i = 0; i < 3; i++) bp[i] = '{1'($urandom_range(0, 1)), $urandom(), $urandom()};
        cap.delete();
        for (int i = 0; i < 3; i++) send(bp[i].w, bp[i].a, bp[i].d);
        drain(1'b0);
        ref_cap = cap;
        cap.delete();
        for (int i = 0; i < 3; i++) begin
            m2h_ready = 1'($urandom_range(0, 1));
            send(bp[i].w, bp[i].a, bp[i].d);
        end
        drain(1'b1);
        check("bp_len", 32'(cap.size()), 32'(3 * PKT_LEN));
        check("bp_ref_len", 32'(ref_cap.size()), 32'(3 * PKT_LEN));
        for (int i = 0; i < cap.size() && i < ref_cap.size(); i++) check("bp_same", 32'(cap[i]), 32'(ref_cap[i]));

        // Overflow: seven back-to-back events with ready low.
        m2h_ready = 1'b0;
        cap.delete();
        for (int i = 0; i < 7; i++) begin
            ov_addr[i] = $urandom();
            send(1'b1, ov_addr[i], $urandom());
        end
        check("ov_level", 32'(fifo_level), 32'd4);
        check("ov_drops", 32'(drop_count), 32'd2);
        drain(1'b0);
        check("ov_len", 32'(cap.size()), 32'(5 * PKT_LEN));
        for (int p = 0; p < 5 && (p * PKT_LEN + 2) < cap.size(); p++) begin
            check("ov_sync", 32'(cap[p*PKT_LEN]), 32'hA5);
            check("ov_order", 32'(cap[p*PKT_LEN+2]), 32'(ov_addr[p][7:0]));
        end

        // Full FIFO plus push on the checksum-handshake pop.
        m2h_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, $urandom(), $urandom());
        check("fp_level_full", 32'(fifo_level), 32'd4);
        m2h_ready = 1'b1;
        begin
            int k = 0;
            while (rem != 1 && k < 100) begin
                tick();
                k++;
            end
            check("fp_wait_timeout", 32'(k >= 100), 32'd0);
        end
        send(1'b1, $urandom(), $urandom());
        check("fp_level", 32'(fifo_level), 32'd4);
        check("fp_drops", 32'(drop_count), 32'd2);
        drain(1'b0);

        // Reset during the address bytes, with an event offered alongside rst.
        m2h_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b1, $urandom(), $urandom());
        begin
            int k = 0;
            while (rem != PKT_LEN - 3 && k < 100) begin
                tick();
                k++;
            end
            check("rm_wait_timeout", 32'(k >= 100), 32'd0);
        end
        rst      = 1'b1;
        ev_valid = 1'b1;
        ev_addr  = $urandom();
        tick();
        rst      = 1'b0;
        ev_valid = 1'b0;
        check("rm_valid", 32'(m2h_valid), 32'd0);
        check("rm_level", 32'(fifo_level), 32'd0);
        check("rm_drops", 32'(drop_count), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        cap.delete();
        send(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        drain(1'b0);
        check("rm_after_len", 32'(cap.size()), 32'(PKT_LEN));
        for (int i = 0; i < PKT_LEN && i < cap.size(); i++) check("rm_after_byte", 32'(cap[i]), 32'(exp_w[i]));

        // Random traffic with random back-pressure.
        for (int c = 0; c < 3000; c++) begin
            ev_valid  = ($urandom_range(0, 5) == 0);
            ev_write  = 1'($urandom_range(0, 1));
            ev_addr   = $urandom();
            ev_data   = $urandom();
            m2h_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(1'b0);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
